// File: rtl/spi_eeprom_responder_if.sv
// SPI pin bundle between a mode-0 master and the EEPROM responder.
//   SCK, CS_N, MOSI : driven by the master
//   MISO, MISO_OE   : driven by the responder (MISO_OE steers an external tri-state)
interface spi_eeprom_responder_if;
    logic SCK;
    logic CS_N;
    logic MOSI;
    logic MISO;
    logic MISO_OE;

    modport master (output SCK, output CS_N, output MOSI, input MISO, input MISO_OE);
    modport slave  (input SCK, input CS_N, input MOSI, output MISO, output MISO_OE);
endinterface

// File: rtl/spi_eeprom_responder.sv
// SPI mode-0 slave emulating the 25xx EEPROM subset (WREN, WRDI, RDSR, WRITE, READ)
// over an on-chip byte memory. SCK/CS_N/MOSI are oversampled on ACLK.
// Ports:
//   ACLK, RST        : system clock, synchronous active-high reset
//   spi (slave)      : SCK, CS_N, MOSI in; MISO, MISO_OE out
//   WEL              : write-enable latch (status bit 1)
//   SELECTED         : synchronized ~CS_N
//   WR_STB/ADDR/DATA : one-cycle report of each committed memory write
module spi_eeprom_responder #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                      ACLK,
    input  logic                      RST,
    spi_eeprom_responder_if.slave     spi,
    output logic                      WEL,
    output logic                      SELECTED,
    output logic                      WR_STB,
    output logic [ADDR_W-1:0]         WR_ADDR,
    output logic [7:0]                WR_DATA
);
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_WRDI  = 8'h04;
    localparam logic [7:0] OP_RDSR  = 8'h05;
    localparam logic [7:0] OP_WREN  = 8'h06;

    typedef enum logic [2:0] {IDLE, CMD, ADDR_H, ADDR_L, WDATA, RDATA, STAT, IGNORE} state_t;

    // Input synchronizers; CS_N resets to deasserted so reset never looks like a select.
    logic [SYNC_N-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic              sck_prev_q, sel_q;

    always_ff @(posedge ACLK) begin
        if (RST) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            sel_q       <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_N-2:0], spi.SCK};
            cs_sync_q   <= {cs_sync_q[SYNC_N-2:0], spi.CS_N};
            mosi_sync_q <= {mosi_sync_q[SYNC_N-2:0], spi.MOSI};
            sck_prev_q  <= sck_sync_q[SYNC_N-1];
            sel_q       <= ~cs_sync_q[SYNC_N-1];
        end
    end

    logic sck_s, cs_s, mosi_s;
    logic sck_rise_c, sck_fall_c, cs_fall_c, cs_rise_c;
    assign sck_s      = sck_sync_q[SYNC_N-1];
    assign cs_s       = cs_sync_q[SYNC_N-1];
    assign mosi_s     = mosi_sync_q[SYNC_N-1];
    assign sck_rise_c = sck_s & ~sck_prev_q;
    assign sck_fall_c = ~sck_s & sck_prev_q;
    // sel_q doubles as the previous CS sample (inverted).
    assign cs_fall_c  = ~cs_s & ~sel_q;
    assign cs_rise_c  = cs_s & sel_q;

    state_t            state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        rx_sr_q, rx_sr_d;
    logic [7:0]        tx_sr_q, tx_sr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              op_write_q, op_write_d;
    logic              wel_q, wel_d;
    logic              miso_q, miso_d;
    logic              oe_q, oe_d;
    logic              wr_stb_q, wr_stb_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic [7:0]        mem_q [DEPTH];
    logic [7:0]        rx_byte_c;
    logic              mem_we_c;

    assign rx_byte_c = {rx_sr_q[6:0], mosi_s};

    // State register
    always_ff @(posedge ACLK) begin
        if (RST) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            rx_sr_q    <= 8'd0;
            tx_sr_q    <= 8'd0;
            addr_q     <= '0;
            op_write_q <= 1'b0;
            wel_q      <= 1'b0;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            wr_stb_q   <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            rx_sr_q    <= rx_sr_d;
            tx_sr_q    <= tx_sr_d;
            addr_q     <= addr_d;
            op_write_q <= op_write_d;
            wel_q      <= wel_d;
            miso_q     <= miso_d;
            oe_q       <= oe_d;
            wr_stb_q   <= wr_stb_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
        end
    end

    // Memory is never reset; committed writes survive RST.
    always_ff @(posedge ACLK) begin
        if (mem_we_c && !RST) begin
            mem_q[addr_q] <= rx_byte_c;
        end
    end

    // Next-state and datapath
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        rx_sr_d    = rx_sr_q;
        tx_sr_d    = tx_sr_q;
        addr_d     = addr_q;
        op_write_d = op_write_q;
        wel_d      = wel_q;
        miso_d     = miso_q;
        wr_stb_d   = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        mem_we_c   = 1'b0;

        if (state_q == IDLE) begin
            if (cs_fall_c) begin
                state_d   = CMD;
                bit_cnt_d = 3'd0;
                rx_sr_d   = 8'd0;
            end
        end else if (cs_rise_c) begin
            // Deselect wins over any same-cycle SCK edge.
            state_d    = IDLE;
            bit_cnt_d  = 3'd0;
            tx_sr_d    = 8'd0;
            op_write_d = 1'b0;
            if (op_write_q) begin
                wel_d = 1'b0;
            end
        end else if (sck_rise_c) begin
            rx_sr_d   = rx_byte_c;
            bit_cnt_d = 3'(bit_cnt_q + 3'd1);
            if (bit_cnt_q == 3'd7) begin
                case (state_q)
                    CMD: begin
                        case (rx_byte_c)
                            OP_WREN: begin wel_d = 1'b1; state_d = IGNORE; end
                            OP_WRDI: begin wel_d = 1'b0; state_d = IGNORE; end
                            OP_RDSR: begin tx_sr_d = {6'b0, wel_q, 1'b0}; state_d = STAT; end
                            OP_WRITE: begin op_write_d = 1'b1; state_d = ADDR_H; end
                            OP_READ: begin op_write_d = 1'b0; state_d = ADDR_H; end
                            default: state_d = IGNORE;
                        endcase
                    end
                    ADDR_H: state_d = ADDR_L;
                    ADDR_L: begin
                        if (op_write_q) begin
                            addr_d  = ADDR_W'(rx_byte_c);
                            state_d = WDATA;
                        end else begin
                            tx_sr_d = mem_q[ADDR_W'(rx_byte_c)];
                            addr_d  = ADDR_W'(rx_byte_c) + ADDR_W'(1);
                            state_d = RDATA;
                        end
                    end
                    WDATA: begin
                        if (wel_q) begin
                            mem_we_c  = 1'b1;
                            wr_stb_d  = 1'b1;
                            wr_addr_d = addr_q;
                            wr_data_d = rx_byte_c;
                        end
                        addr_d = addr_q + ADDR_W'(1);
                    end
                    RDATA: begin
                        tx_sr_d = mem_q[addr_q];
                        addr_d  = addr_q + ADDR_W'(1);
                    end
                    STAT: tx_sr_d = {6'b0, wel_q, 1'b0};
                    default: ;
                endcase
            end
        end else if (sck_fall_c) begin
            miso_d  = tx_sr_q[7];
            tx_sr_d = {tx_sr_q[6:0], 1'b0};
        end

        oe_d = (state_d == RDATA) || (state_d == STAT);
        // MISO is held low whenever the pin is not driven.
        if (!oe_d) begin
            miso_d = 1'b0;
        end
    end

    assign spi.MISO    = miso_q;
    assign spi.MISO_OE = oe_q;
    assign WEL         = wel_q;
    assign SELECTED    = sel_q;
    assign WR_STB      = wr_stb_q;
    assign WR_ADDR     = wr_addr_q;
    assign WR_DATA     = wr_data_q;
endmodule

// File: tb/tb_spi_eeprom_responder.sv
// Self-checking bench: a transaction-level EEPROM model predicts MISO bytes,
// MISO_OE per byte, WEL and the committed-write stream; a monitor checks
// WR_STB and idle MISO every cycle.
module tb_spi_eeprom_responder;
    localparam int HALF = 8;   // SCK = ACLK/16

    logic ACLK = 1'b0;
    logic RST;
    logic WEL, SELECTED, WR_STB;
    logic [7:0] WR_ADDR, WR_DATA;

    always #5 ACLK = ~ACLK;

    spi_eeprom_responder_if bus();

    spi_eeprom_responder #(.ADDR_W(8), .SYNC_STAGES(2)) dut (
        .ACLK(ACLK), .RST(RST), .spi(bus.slave),
        .WEL(WEL), .SELECTED(SELECTED), .WR_STB(WR_STB),
        .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Reference model state
    logic [7:0] mem_m [256];
    bit         valid_m [256];
    bit         wel_m = 1'b0;
    logic [7:0] tx_q[$];
    logic [7:0] exp_rx[$];
    bit         exp_known[$];
    bit         exp_oe[$];
    logic [7:0] exp_wa[$];
    logic [7:0] exp_wd[$];
    logic [7:0] rx_got[$];

    // Monitor state
    bit         mon_en = 1'b0;
    int         strobe_cnt = 0;
    logic [7:0] last_wa = 8'h00;
    logic [7:0] last_wd = 8'h00;

    always @(negedge ACLK) begin
        if (mon_en && !RST) begin
            if (!bus.MISO_OE) check("miso_idle_low", 32'(bus.MISO), 32'd0);
            if (WR_STB) begin
                strobe_cnt++;
                last_wa = WR_ADDR;
                last_wd = WR_DATA;
                if (exp_wa.size() == 0) begin
                    check("unexpected_wr_stb", 32'(WR_STB), 32'd0);
                end else begin
                    check("wr_addr", 32'(WR_ADDR), 32'(exp_wa.pop_front()));
                    check("wr_data", 32'(WR_DATA), 32'(exp_wd.pop_front()));
                end
            end
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge ACLK);
        #1;
    endtask

    // Predict one transaction from the bytes in tx_q (all full bytes).
    task automatic model_txn();
        int n = tx_q.size();
        int addr = 0;
        logic [7:0] op;
        exp_rx.delete(); exp_known.delete(); exp_oe.delete();
        op = (n > 0) ? tx_q[0] : 8'h00;
        for (int i = 0; i < n; i++) begin
            if (op == 8'h05 && i >= 1) begin
                exp_rx.push_back(wel_m ? 8'h02 : 8'h00);
                exp_known.push_back(1'b1);
                exp_oe.push_back(1'b1);
            end else if (op == 8'h03 && i >= 3) begin
                exp_rx.push_back(mem_m[addr]);
                exp_known.push_back(valid_m[addr]);
                exp_oe.push_back(1'b1);
                addr = (addr + 1) % 256;
            end else begin
                exp_rx.push_back(8'h00);
                exp_known.push_back(1'b1);
                exp_oe.push_back(1'b0);
            end
            if ((op == 8'h02 || op == 8'h03) && i == 2) addr = int'(tx_q[2]);
            if (op == 8'h02 && i >= 3) begin
                if (wel_m) begin
                    mem_m[addr]   = tx_q[i];
                    valid_m[addr] = 1'b1;
                    exp_wa.push_back(8'(addr));
                    exp_wd.push_back(tx_q[i]);
                end
                addr = (addr + 1) % 256;
            end
            if (i == 0 && op == 8'h06) wel_m = 1'b1;
            if (i == 0 && op == 8'h04) wel_m = 1'b0;
        end
        if (n >= 1 && op == 8'h02) wel_m = 1'b0;
    endtask

    // Shift nb bits of b MSB first; MISO and MISO_OE sampled just before each rise.
    task automatic spi_bits(input logic [7:0] b, input int nb, output logic [7:0] rx, output logic [7:0] oe);
        rx = 8'h00;
        oe = 8'h00;
        for (int k = 0; k < nb; k++) begin
            bus.MOSI = b[7-k];
            wait_cyc(HALF);
            rx = {rx[6:0], bus.MISO};
            oe = {oe[6:0], bus.MISO_OE};
            bus.SCK = 1'b1;
            wait_cyc(HALF);
            bus.SCK = 1'b0;
        end
    endtask

    task automatic cs_low();
        bus.CS_N = 1'b0;
        wait_cyc(HALF);
        check("selected_on", 32'(SELECTED), 32'd1);
    endtask

    task automatic cs_high();
        wait_cyc(HALF);
        bus.CS_N = 1'b1;
        wait_cyc(16);
        check("selected_off", 32'(SELECTED), 32'd0);
        check("oe_after_deselect", 32'(bus.MISO_OE), 32'd0);
        check("strobes_drained", 32'(exp_wa.size()), 32'd0);
    endtask

    task automatic run_txn(input string name, input int extra);
        logic [7:0] rx, oe;
        model_txn();
        rx_got.delete();
        cs_low();
        for (int i = 0; i < tx_q.size(); i++) begin
            spi_bits(tx_q[i], 8, rx, oe);
            rx_got.push_back(rx);
            if (exp_known[i]) check($sformatf("%s_rx%0d", name, i), 32'(rx), 32'(exp_rx[i]));
            check($sformatf("%s_oe%0d", name, i), 32'(oe), exp_oe[i] ? 32'hFF : 32'h00);
        end
        if (extra > 0) spi_bits(8'($urandom), extra, rx, oe);
        cs_high();
        check($sformatf("%s_wel", name), 32'(WEL), 32'(wel_m));
    endtask

    initial begin
        logic [7:0] rx, oe;
        int s0;
        bus.SCK  = 1'b0;
        bus.CS_N = 1'b1;
        bus.MOSI = 1'b0;
        RST      = 1'b1;
        wait_cyc(4);
        check("rst_miso", 32'(bus.MISO), 32'd0);
        check("rst_oe", 32'(bus.MISO_OE), 32'd0);
        check("rst_wel", 32'(WEL), 32'd0);
        check("rst_selected", 32'(SELECTED), 32'd0);
        check("rst_wr_stb", 32'(WR_STB), 32'd0);
        check("rst_wr_addr", 32'(WR_ADDR), 32'd0);
        check("rst_wr_data", 32'(WR_DATA), 32'd0);
        RST = 1'b0;
        mon_en = 1'b1;
        wait_cyc(4);

        // RDSR after reset
        tx_q = '{8'h05, 8'h00};
        run_txn("rdsr0", 0);
        check("lit_rdsr0", 32'(rx_got[1]), 32'h00);

        // WREN then RDSR
        tx_q = '{8'h06};
        run_txn("wren", 0);
        tx_q = '{8'h05, 8'h00};
        run_txn("rdsr1", 0);
        check("lit_rdsr1", 32'(rx_got[1]), 32'h02);

        // WRITE 0xAA to 0xF0, read it back
        s0 = strobe_cnt;
        tx_q = '{8'h02, 8'h00, 8'hF0, 8'hAA};
        run_txn("wr_f0", 0);
        check("lit_stb_cnt1", 32'(strobe_cnt - s0), 32'd1);
        check("lit_stb_addr1", 32'(last_wa), 32'hF0);
        check("lit_stb_data1", 32'(last_wd), 32'hAA);
        tx_q = '{8'h03, 8'h00, 8'hF0, 8'h00};
        run_txn("rd_f0", 0);
        check("lit_rd_f0", 32'(rx_got[3]), 32'hAA);

        // WRITE without WREN commits nothing
        s0 = strobe_cnt;
        tx_q = '{8'h02, 8'h00, 8'hF0, 8'h55};
        run_txn("wr_nowel", 0);
        check("lit_stb_cnt_nowel", 32'(strobe_cnt - s0), 32'd0);
        tx_q = '{8'h03, 8'h00, 8'hF0, 8'h00};
        run_txn("rd_f0b", 0);
        check("lit_rd_f0b", 32'(rx_got[3]), 32'hAA);

        // Address wrap on write and read
        tx_q = '{8'h06};
        run_txn("wren2", 0);
        s0 = strobe_cnt;
        tx_q = '{8'h02, 8'h00, 8'hFF, 8'h11, 8'h22};
        run_txn("wr_wrap", 0);
        check("lit_stb_cnt_wrap", 32'(strobe_cnt - s0), 32'd2);
        check("lit_stb_addr_wrap", 32'(last_wa), 32'h00);
        check("lit_stb_data_wrap", 32'(last_wd), 32'h22);
        tx_q = '{8'h03, 8'h00, 8'hFF, 8'h00, 8'h00};
        run_txn("rd_wrap", 0);
        check("lit_rd_wrap0", 32'(rx_got[3]), 32'h11);
        check("lit_rd_wrap1", 32'(rx_got[4]), 32'h22);

        // Deselect after 4 bits of the READ low address byte
        tx_q = '{8'h03, 8'h00};
        run_txn("rd_abort", 4);
        tx_q = '{8'h05, 8'h00};
        run_txn("rdsr_after_abort", 0);

        // Reset pulsed in the middle of a write data byte
        tx_q = '{8'h06};
        run_txn("wren3", 0);
        tx_q = '{8'h02, 8'h00, 8'h40, 8'h5A};
        model_txn();
        wel_m = 1'b0;
        cs_low();
        for (int i = 0; i < tx_q.size(); i++) spi_bits(tx_q[i], 8, rx, oe);
        s0 = strobe_cnt;
        spi_bits(8'hC3, 4, rx, oe);
        RST = 1'b1;
        wait_cyc(2);
        RST = 1'b0;
        cs_high();
        check("rst_mid_wel", 32'(WEL), 32'd0);
        check("rst_mid_no_stb", 32'(strobe_cnt - s0), 32'd0);
        tx_q = '{8'h02, 8'h00, 8'h40, 8'h99};
        run_txn("wr_after_rst", 0);
        tx_q = '{8'h03, 8'h00, 8'h40, 8'h00};
        run_txn("rd_40", 0);
        check("lit_rd_40", 32'(rx_got[3]), 32'h5A);

        // Unknown opcode keeps MISO undriven
        tx_q = '{8'hFF, 8'h00, 8'h00};
        run_txn("unknown_op", 0);

        // Randomized transactions
        for (int t = 0; t < 30; t++) begin
            int k = int'($urandom_range(0, 5));
            int extra;
            logic [7:0] op;
            case (k)
                0: op = 8'h06;
                1: op = 8'h04;
                2: op = 8'h05;
                3: op = 8'h02;
                4: op = 8'h03;
                default: begin
                    op = 8'($urandom);
                    if (op >= 8'h02 && op <= 8'h06) op = 8'hA5;
                end
            endcase
            tx_q = '{op};
            if (op == 8'h02 || op == 8'h03) begin
                tx_q.push_back(8'($urandom));
                tx_q.push_back(8'(8'hF8 + 8'($urandom_range(0, 15))));
                for (int d = 0; d < int'($urandom_range(1, 3)); d++) tx_q.push_back(8'($urandom));
            end else if (op == 8'h05) begin
                for (int d = 0; d < int'($urandom_range(1, 2)); d++) tx_q.push_back(8'($urandom));
            end else begin
                for (int d = 0; d < int'($urandom_range(0, 1)); d++) tx_q.push_back(8'($urandom));
            end
            extra = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0;
            run_txn($sformatf("rnd%0d", t), extra);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
